// File: rtl/reg_writeback_unit.sv
// Purpose: register-file write-back queue; merges load and ALU results in order, retires one per cycle to GPR or PC port.
// Latency: result accepted at edge E0 is presented on REG_WR_SEL/PC_REG_EN after E1 and captured by the register file at E2.
// Backpressure: LD_READY/ALU_READY derive only from the registered occupancy (no same-cycle pop credit); load has priority over ALU.
//
// Ports:
//   CLK, ACLR                       clock (rising edge), asynchronous active-high reset
//   FLUSH                           synchronous discard of queued and in-flight results
//   LD_VALID/LD_READY/LD_DEST/LD_DATA      load result handshake
//   ALU_VALID/ALU_READY/ALU_DEST/ALU_DATA  ALU result handshake
//   REG_WR_SEL/REG_INPUT_BUS        GPR write port (select 4'hF = no write)
//   PC_IN_BUS/PC_REG_EN             PC write port (destination r15)
//   PENDING                         one bit per register with a write queued or on the outputs
//   FIFO_COUNT                      occupied queue entries
module reg_writeback_unit #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       CLK,
    input  logic                       ACLR,
    input  logic                       FLUSH,
    input  logic                       LD_VALID,
    input  logic [3:0]                 LD_DEST,
    input  logic [DATA_WIDTH-1:0]      LD_DATA,
    output logic                       LD_READY,
    input  logic                       ALU_VALID,
    input  logic [3:0]                 ALU_DEST,
    input  logic [DATA_WIDTH-1:0]      ALU_DATA,
    output logic                       ALU_READY,
    output logic [3:0]                 REG_WR_SEL,
    output logic [DATA_WIDTH-1:0]      REG_INPUT_BUS,
    output logic [DATA_WIDTH-1:0]      PC_IN_BUS,
    output logic                       PC_REG_EN,
    output logic [15:0]                PENDING,
    output logic [$clog2(DEPTH):0]     FIFO_COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // select 15 is the only "no write" code: the register file decoder has no enable
    localparam logic [3:0] SEL_IDLE = 4'hF;

    logic [3:0]            fifo_dest [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         alu_slot;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  ld_push;
    logic                  alu_push;
    logic                  pop;

    // ALU needs room for two entries when the load is competing for the same cycle
    assign LD_READY   = (count <= CW'(DEPTH - 1));
    assign ALU_READY  = LD_VALID ? (count <= CW'(DEPTH - 2)) : (count <= CW'(DEPTH - 1));
    assign ld_push    = LD_VALID & LD_READY;
    assign alu_push   = ALU_VALID & ALU_READY;
    assign pop        = (count != '0);
    assign FIFO_COUNT = count;

    // load goes first, so a same-cycle ALU result lands one slot behind it
    assign alu_slot   = wr_ptr + PW'(ld_push);
    assign count_next = count + CW'(ld_push) + CW'(alu_push) - CW'(pop);

    // payload storage needs no reset: only entries inside [rd_ptr, rd_ptr+count) are ever read
    always_ff @(posedge CLK) begin
        if (!FLUSH) begin
            if (ld_push) begin
                fifo_dest[wr_ptr] <= LD_DEST;
                fifo_data[wr_ptr] <= LD_DATA;
            end
            if (alu_push) begin
                fifo_dest[alu_slot] <= ALU_DEST;
                fifo_data[alu_slot] <= ALU_DATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            REG_WR_SEL    <= SEL_IDLE;
            REG_INPUT_BUS <= '0;
            PC_IN_BUS     <= '0;
            PC_REG_EN     <= 1'b0;
        end else if (FLUSH) begin
            // the write presented during this cycle is still captured at this edge
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            REG_WR_SEL <= SEL_IDLE;
            PC_REG_EN  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(ld_push) + PW'(alu_push);
            count  <= count_next;
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (fifo_dest[rd_ptr] == SEL_IDLE) begin
                    REG_WR_SEL <= SEL_IDLE;
                    PC_IN_BUS  <= fifo_data[rd_ptr];
                    PC_REG_EN  <= 1'b1;
                end else begin
                    REG_WR_SEL    <= fifo_dest[rd_ptr];
                    REG_INPUT_BUS <= fifo_data[rd_ptr];
                    PC_REG_EN     <= 1'b0;
                end
            end else begin
                // data buses keep their value; only the enables go idle
                REG_WR_SEL <= SEL_IDLE;
                PC_REG_EN  <= 1'b0;
            end
        end
    end

    // hazard mask: every queued destination plus whatever is on the write ports now
    always_comb begin
        PENDING = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                PENDING[fifo_dest[rd_ptr + PW'(i)]] = 1'b1;
            end
        end
        if (REG_WR_SEL != SEL_IDLE) begin
            PENDING[REG_WR_SEL] = 1'b1;
        end
        if (PC_REG_EN) begin
            PENDING[15] = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Purpose: self-checking bench for reg_writeback_unit against a queue-level reference model.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next edge.
// Backpressure: offers are held until the model says they were accepted.
module tb_reg_writeback_unit;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    typedef struct packed {
        logic [3:0]    dest;
        logic [DW-1:0] data;
    } ent_t;

    logic          CLK = 1'b0;
    logic          ACLR = 1'b0;
    logic          FLUSH = 1'b0;
    logic          LD_VALID = 1'b0;
    logic [3:0]    LD_DEST = '0;
    logic [DW-1:0] LD_DATA = '0;
    logic          LD_READY;
    logic          ALU_VALID = 1'b0;
    logic [3:0]    ALU_DEST = '0;
    logic [DW-1:0] ALU_DATA = '0;
    logic          ALU_READY;
    logic [3:0]    REG_WR_SEL;
    logic [DW-1:0] REG_INPUT_BUS;
    logic [DW-1:0] PC_IN_BUS;
    logic          PC_REG_EN;
    logic [15:0]   PENDING;
    logic [2:0]    FIFO_COUNT;

    reg_writeback_unit #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .ACLR(ACLR), .FLUSH(FLUSH),
        .LD_VALID(LD_VALID), .LD_DEST(LD_DEST), .LD_DATA(LD_DATA), .LD_READY(LD_READY),
        .ALU_VALID(ALU_VALID), .ALU_DEST(ALU_DEST), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
        .REG_WR_SEL(REG_WR_SEL), .REG_INPUT_BUS(REG_INPUT_BUS),
        .PC_IN_BUS(PC_IN_BUS), .PC_REG_EN(PC_REG_EN),
        .PENDING(PENDING), .FIFO_COUNT(FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // reference model: queue of accepted results plus what the write ports show
    ent_t          mq[$];
    ent_t          hd;
    logic [3:0]    m_sel;
    logic [DW-1:0] m_rdata, m_pcdata;
    logic          m_pcen;
    logic          exp_ld_rdy, exp_alu_rdy, act_ld_rdy, act_alu_rdy;
    logic          acc_ld, acc_alu;

    logic [3:0]    ld_d, alu_d;
    logic [DW-1:0] ld_x, alu_x;
    logic          ld_v, alu_v;

    function automatic logic [15:0] model_pending();
        logic [15:0] m = '0;
        foreach (mq[i]) m[mq[i].dest] = 1'b1;
        if (m_sel != 4'hF) m[m_sel] = 1'b1;
        if (m_pcen) m[15] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_sel = 4'hF; m_rdata = '0; m_pcdata = '0; m_pcen = 1'b0;
    endtask

    // one clock: drive, capture readies, advance the model across the edge
    task automatic cyc(input logic ldv, input logic [3:0] ldd, input logic [DW-1:0] ldx,
                       input logic aluv, input logic [3:0] alud, input logic [DW-1:0] alux,
                       input logic fl);
        LD_VALID = ldv; LD_DEST = ldd; LD_DATA = ldx;
        ALU_VALID = aluv; ALU_DEST = alud; ALU_DATA = alux; FLUSH = fl;
        exp_ld_rdy  = (mq.size() < DEPTH);
        exp_alu_rdy = ldv ? (mq.size() < DEPTH - 1) : (mq.size() < DEPTH);
        #1;
        act_ld_rdy = LD_READY; act_alu_rdy = ALU_READY;
        @(posedge CLK);
        acc_ld  = ldv && exp_ld_rdy;
        acc_alu = aluv && exp_alu_rdy;
        if (fl) begin
            mq.delete();
            m_sel = 4'hF; m_pcen = 1'b0;
        end else begin
            if (mq.size() > 0) begin
                hd = mq.pop_front();
                if (hd.dest == 4'hF) begin
                    m_sel = 4'hF; m_pcdata = hd.data; m_pcen = 1'b1;
                end else begin
                    m_sel = hd.dest; m_rdata = hd.data; m_pcen = 1'b0;
                end
            end else begin
                m_sel = 4'hF; m_pcen = 1'b0;
            end
            if (acc_ld)  mq.push_back('{dest: ldd, data: ldx});
            if (acc_alu) mq.push_back('{dest: alud, data: alux});
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, '0, 1'b0, 4'h0, '0, 1'b0);
    endtask

    task automatic test_reset();
        #2 ACLR = 1'b1;
        #1;
        n_vec++; if (REG_WR_SEL !== 4'hF) begin $display("FAIL reset_sel got %h want f", REG_WR_SEL); n_err++; end
        n_vec++; if (REG_INPUT_BUS !== '0) begin $display("FAIL reset_rdata got %h want 0", REG_INPUT_BUS); n_err++; end
        n_vec++; if (PC_IN_BUS !== '0) begin $display("FAIL reset_pcdata got %h want 0", PC_IN_BUS); n_err++; end
        n_vec++; if (PC_REG_EN !== 1'b0) begin $display("FAIL reset_pcen got %b want 0", PC_REG_EN); n_err++; end
        n_vec++; if (PENDING !== 16'h0) begin $display("FAIL reset_pending got %h want 0", PENDING); n_err++; end
        n_vec++; if (FIFO_COUNT !== 3'd0) begin $display("FAIL reset_count got %0d want 0", FIFO_COUNT); n_err++; end
        n_vec++; if (LD_READY !== 1'b1) begin $display("FAIL reset_ld_rdy got %b want 1", LD_READY); n_err++; end
        n_vec++; if (ALU_READY !== 1'b1) begin $display("FAIL reset_alu_rdy got %b want 1", ALU_READY); n_err++; end
        @(negedge CLK) ACLR = 1'b0;
        model_reset();
        @(posedge CLK); #1;
    endtask

    task automatic test_single_alu();
        cyc(1'b0, 4'h0, '0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
        n_vec++; if (act_alu_rdy !== 1'b1) begin $display("FAIL single_alu_rdy got %b want 1", act_alu_rdy); n_err++; end
        n_vec++; if (FIFO_COUNT !== 3'd1) begin $display("FAIL single_count got %0d want 1", FIFO_COUNT); n_err++; end
        n_vec++; if (PENDING !== 16'h0008) begin $display("FAIL single_pend_e0 got %h want 0008", PENDING); n_err++; end
        n_vec++; if (REG_WR_SEL !== 4'hF) begin $display("FAIL single_sel_e0 got %h want f", REG_WR_SEL); n_err++; end
        idle();
        n_vec++; if (REG_WR_SEL !== 4'd3) begin $display("FAIL single_sel_e1 got %h want 3", REG_WR_SEL); n_err++; end
        n_vec++; if (REG_INPUT_BUS !== 32'hDEADBEEF) begin $display("FAIL single_data got %h want deadbeef", REG_INPUT_BUS); n_err++; end
        n_vec++; if (PENDING !== 16'h0008) begin $display("FAIL single_pend_e1 got %h want 0008", PENDING); n_err++; end
        idle();
        n_vec++; if (REG_WR_SEL !== 4'hF) begin $display("FAIL single_sel_e2 got %h want f", REG_WR_SEL); n_err++; end
        n_vec++; if (PENDING !== 16'h0) begin $display("FAIL single_pend_e2 got %h want 0", PENDING); n_err++; end
    endtask

    task automatic test_same_dest();
        cyc(1'b1, 4'd5, 32'h1111, 1'b1, 4'd5, 32'h2222, 1'b0);
        n_vec++; if ({act_ld_rdy, act_alu_rdy} !== 2'b11) begin $display("FAIL same_rdy got %b want 11", {act_ld_rdy, act_alu_rdy}); n_err++; end
        n_vec++; if (FIFO_COUNT !== 3'd2) begin $display("FAIL same_count got %0d want 2", FIFO_COUNT); n_err++; end
        n_vec++; if (PENDING !== 16'h0020) begin $display("FAIL same_pend got %h want 0020", PENDING); n_err++; end
        idle();
        n_vec++; if (REG_WR_SEL !== 4'd5 || REG_INPUT_BUS !== 32'h1111) begin
            $display("FAIL same_first got %h/%h want 5/1111", REG_WR_SEL, REG_INPUT_BUS); n_err++; end
        idle();
        n_vec++; if (REG_WR_SEL !== 4'd5 || REG_INPUT_BUS !== 32'h2222) begin
            $display("FAIL same_second got %h/%h want 5/2222", REG_WR_SEL, REG_INPUT_BUS); n_err++; end
        idle();
        n_vec++; if (REG_WR_SEL !== 4'hF || PENDING !== 16'h0) begin
            $display("FAIL same_idle got %h/%h want f/0000", REG_WR_SEL, PENDING); n_err++; end
    endtask

    task automatic test_fill();
        ld_d = 4'($urandom_range(0, 14)); ld_x = $urandom;
        alu_d = 4'($urandom_range(0, 14)); alu_x = $urandom;
        for (int c = 0; c < 16; c++) begin
            ld_v = (c < 10); alu_v = (c < 10);
            cyc(ld_v, ld_d, ld_x, alu_v, alu_d, alu_x, 1'b0);
            if (acc_ld)  begin ld_d = 4'($urandom_range(0, 14)); ld_x = $urandom; end
            if (acc_alu) begin alu_d = 4'($urandom_range(0, 14)); alu_x = $urandom; end
            n_vec++; if (act_ld_rdy !== exp_ld_rdy) begin $display("FAIL fill_ld_rdy c%0d got %b want %b", c, act_ld_rdy, exp_ld_rdy); n_err++; end
            n_vec++; if (act_alu_rdy !== exp_alu_rdy) begin $display("FAIL fill_alu_rdy c%0d got %b want %b", c, act_alu_rdy, exp_alu_rdy); n_err++; end
            n_vec++; if (REG_WR_SEL !== m_sel) begin $display("FAIL fill_sel c%0d got %h want %h", c, REG_WR_SEL, m_sel); n_err++; end
            n_vec++; if (REG_INPUT_BUS !== m_rdata) begin $display("FAIL fill_rdata c%0d got %h want %h", c, REG_INPUT_BUS, m_rdata); n_err++; end
            n_vec++; if (FIFO_COUNT !== 3'(mq.size())) begin $display("FAIL fill_count c%0d got %0d want %0d", c, FIFO_COUNT, mq.size()); n_err++; end
            n_vec++; if (PENDING !== model_pending()) begin $display("FAIL fill_pend c%0d got %h want %h", c, PENDING, model_pending()); n_err++; end
        end
    endtask

    task automatic test_pc_write();
        cyc(1'b0, 4'h0, '0, 1'b1, 4'd15, 32'h00000100, 1'b0);
        n_vec++; if (PENDING !== 16'h8000) begin $display("FAIL pc_pend_e0 got %h want 8000", PENDING); n_err++; end
        n_vec++; if (REG_WR_SEL !== 4'hF || PC_REG_EN !== 1'b0) begin
            $display("FAIL pc_e0 got %h/%b want f/0", REG_WR_SEL, PC_REG_EN); n_err++; end
        idle();
        n_vec++; if (PC_REG_EN !== 1'b1 || PC_IN_BUS !== 32'h100) begin
            $display("FAIL pc_write got %b/%h want 1/00000100", PC_REG_EN, PC_IN_BUS); n_err++; end
        n_vec++; if (REG_WR_SEL !== 4'hF) begin $display("FAIL pc_sel got %h want f", REG_WR_SEL); n_err++; end
        n_vec++; if (REG_INPUT_BUS !== m_rdata) begin $display("FAIL pc_rdata_hold got %h want %h", REG_INPUT_BUS, m_rdata); n_err++; end
        n_vec++; if (PENDING !== 16'h8000) begin $display("FAIL pc_pend_e1 got %h want 8000", PENDING); n_err++; end
        idle();
        n_vec++; if (PC_REG_EN !== 1'b0 || PENDING !== 16'h0 || REG_WR_SEL !== 4'hF) begin
            $display("FAIL pc_e2 got %b/%h/%h want 0/0000/f", PC_REG_EN, PENDING, REG_WR_SEL); n_err++; end
    endtask

    task automatic test_flush();
        cyc(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hA2, 1'b0);
        cyc(1'b1, 4'd3, 32'hA3, 1'b1, 4'd4, 32'hA4, 1'b0);
        n_vec++; if (FIFO_COUNT !== 3'd3 || REG_WR_SEL !== 4'd1 || REG_INPUT_BUS !== 32'hA1) begin
            $display("FAIL flush_pre got %0d/%h/%h want 3/1/a1", FIFO_COUNT, REG_WR_SEL, REG_INPUT_BUS); n_err++; end
        n_vec++; if (PENDING !== 16'h001E) begin $display("FAIL flush_pre_pend got %h want 001e", PENDING); n_err++; end
        cyc(1'b1, 4'd6, 32'hA6, 1'b0, 4'h0, '0, 1'b1);
        n_vec++; if (act_ld_rdy !== 1'b1) begin $display("FAIL flush_ld_rdy got %b want 1", act_ld_rdy); n_err++; end
        n_vec++; if (FIFO_COUNT !== 3'd0 || PENDING !== 16'h0) begin
            $display("FAIL flush_post got %0d/%h want 0/0000", FIFO_COUNT, PENDING); n_err++; end
        n_vec++; if (REG_WR_SEL !== 4'hF || PC_REG_EN !== 1'b0) begin
            $display("FAIL flush_out got %h/%b want f/0", REG_WR_SEL, PC_REG_EN); n_err++; end
        for (int c = 0; c < 3; c++) begin
            idle();
            n_vec++; if (REG_WR_SEL !== 4'hF || FIFO_COUNT !== 3'd0 || PC_REG_EN !== 1'b0) begin
                $display("FAIL flush_stale c%0d got %h/%0d/%b want f/0/0", c, REG_WR_SEL, FIFO_COUNT, PC_REG_EN); n_err++; end
        end
    endtask

    task automatic test_aclr_midop();
        cyc(1'b1, 4'd7, 32'hB7, 1'b1, 4'd8, 32'hB8, 1'b0);
        cyc(1'b1, 4'd9, 32'hB9, 1'b0, 4'h0, '0, 1'b0);
        n_vec++; if (FIFO_COUNT !== 3'd2 || REG_WR_SEL !== 4'd7 || REG_INPUT_BUS !== 32'hB7) begin
            $display("FAIL aclr_pre got %0d/%h/%h want 2/7/b7", FIFO_COUNT, REG_WR_SEL, REG_INPUT_BUS); n_err++; end
        LD_VALID = 1'b0; ALU_VALID = 1'b0;
        #2 ACLR = 1'b1;
        #1;
        n_vec++; if (FIFO_COUNT !== 3'd0 || PENDING !== 16'h0) begin
            $display("FAIL aclr_state got %0d/%h want 0/0000", FIFO_COUNT, PENDING); n_err++; end
        n_vec++; if (REG_WR_SEL !== 4'hF || REG_INPUT_BUS !== '0 || PC_IN_BUS !== '0 || PC_REG_EN !== 1'b0) begin
            $display("FAIL aclr_out got %h/%h/%h/%b want f/0/0/0", REG_WR_SEL, REG_INPUT_BUS, PC_IN_BUS, PC_REG_EN); n_err++; end
        #2 ACLR = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        for (int c = 0; c < 3; c++) begin
            idle();
            n_vec++; if (REG_WR_SEL !== 4'hF || FIFO_COUNT !== 3'd0 || PC_REG_EN !== 1'b0) begin
                $display("FAIL aclr_stale c%0d got %h/%0d/%b want f/0/0", c, REG_WR_SEL, FIFO_COUNT, PC_REG_EN); n_err++; end
        end
    endtask

    task automatic test_random();
        ld_v = 1'b0; alu_v = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!ld_v)  begin ld_v = 1'($urandom_range(0, 1)); ld_d = 4'($urandom_range(0, 15)); ld_x = $urandom; end
            if (!alu_v) begin alu_v = 1'($urandom_range(0, 1)); alu_d = 4'($urandom_range(0, 15)); alu_x = $urandom; end
            cyc(ld_v, ld_d, ld_x, alu_v, alu_d, alu_x, ($urandom_range(0, 19) == 0));
            if (acc_ld)  ld_v = 1'b0;
            if (acc_alu) alu_v = 1'b0;
            n_vec++; if (act_ld_rdy !== exp_ld_rdy) begin $display("FAIL rnd_ld_rdy c%0d got %b want %b", c, act_ld_rdy, exp_ld_rdy); n_err++; end
            n_vec++; if (act_alu_rdy !== exp_alu_rdy) begin $display("FAIL rnd_alu_rdy c%0d got %b want %b", c, act_alu_rdy, exp_alu_rdy); n_err++; end
            n_vec++; if (REG_WR_SEL !== m_sel) begin $display("FAIL rnd_sel c%0d got %h want %h", c, REG_WR_SEL, m_sel); n_err++; end
            n_vec++; if (REG_INPUT_BUS !== m_rdata) begin $display("FAIL rnd_rdata c%0d got %h want %h", c, REG_INPUT_BUS, m_rdata); n_err++; end
            n_vec++; if (PC_REG_EN !== m_pcen || PC_IN_BUS !== m_pcdata) begin
                $display("FAIL rnd_pc c%0d got %b/%h want %b/%h", c, PC_REG_EN, PC_IN_BUS, m_pcen, m_pcdata); n_err++; end
            n_vec++; if (FIFO_COUNT !== 3'(mq.size())) begin $display("FAIL rnd_count c%0d got %0d want %0d", c, FIFO_COUNT, mq.size()); n_err++; end
            n_vec++; if (PENDING !== model_pending()) begin $display("FAIL rnd_pend c%0d got %h want %h", c, PENDING, model_pending()); n_err++; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_alu();
        test_same_dest();
        test_fill();
        test_pc_write();
        test_flush();
        test_aclr_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Write-side companion of the CPU register file. Collects results from the load unit and the ALU over valid/ready handshakes.
- Buffers the results in a small in-order FIFO and retires one result per cycle onto the register file write port (REG_WR_SEL/REG_INPUT_BUS).
- A write to r15 goes to the PC write port (PC_IN_BUS/PC_REG_EN) instead.
- Publishes a pending-destination mask that operand fetch uses for hazard stalls.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- DATA_WIDTH, 32, result and register width.

Ports:
- CLK  in  1  system clock, rising edge.
- ACLR  in  1  asynchronous reset, active high.
- FLUSH  in  1  synchronous discard of all queued and in-flight results.
- LD_VALID  in  1  load result offered.
- LD_DEST  in  4  load destination register.
- LD_DATA  in  DATA_WIDTH  load result.
- LD_READY  out  1  load result accepted this cycle when high with LD_VALID.
- ALU_VALID  in  1  ALU result offered.
- ALU_DEST  in  4  ALU destination register.
- ALU_DATA  in  DATA_WIDTH  ALU result.
- ALU_READY  out  1  ALU result accepted this cycle when high with ALU_VALID.
- REG_WR_SEL  out  4  register file write select; 4'hF means no GPR write.
- REG_INPUT_BUS  out  DATA_WIDTH  register file write data.
- PC_IN_BUS  out  DATA_WIDTH  PC write data.
- PC_REG_EN  out  1  PC write enable.
- PENDING  out  16  bit n set = a write to register n is queued or in flight.
- FIFO_COUNT  out  log2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset: ACLR clears everything immediately, regardless of CLK.
  - FIFO is emptied and FIFO_COUNT=0.
  - REG_WR_SEL=4'hF, REG_INPUT_BUS=0, PC_IN_BUS=0, PC_REG_EN=0, PENDING=0.
  - LD_READY and ALU_READY follow from count=0.
  - Reset mid-operation drops every queued result; none is written.
- Idle encoding: the register file decoder has no enable, so select 15 is the only no-write code. REG_WR_SEL stays 4'hF whenever no GPR write is being presented.
- Ready rules: all readies are combinational from the registered count only. There is no pass-through credit from a same-cycle pop.
  - LD_READY = (count <= DEPTH-1).
  - ALU_READY = (count <= DEPTH-1) when LD_VALID is low.
  - ALU_READY = (count <= DEPTH-2) when LD_VALID is high.
- Enqueue order: when both results are accepted in one cycle, the load result is enqueued before the ALU result. If both target the same register, the ALU value is the one that persists.
- Retire: each cycle with count > 0, the head entry is popped into the output stage at the clock edge. In the following cycle:
  - dest 0..14: REG_WR_SEL=dest, REG_INPUT_BUS=data, PC_REG_EN=0.
  - dest 15: REG_WR_SEL=4'hF, PC_IN_BUS=data, PC_REG_EN=1; REG_INPUT_BUS holds its previous value.
  - When count = 0 at the edge, the output stage returns to idle: REG_WR_SEL=4'hF, PC_REG_EN=0, data buses hold their values.
- Latency: a result accepted at edge E0 is driven on the outputs after E1 and is captured by the register file or PC at E2. One retire per cycle gives sustained throughput of 1 result/cycle.
- Count update: count_next = count + pushes - pop, where pushes is 0..2 and pop is 0..1. Pointers wrap modulo DEPTH. Push and pop in the same cycle at count=DEPTH is impossible, because readies are already low.
- PENDING: OR of one-hot(dest) over all valid FIFO entries, plus the output stage entry while it is non-idle. Purely combinational from registered state. Bit 15 tracks PC writes.
- FLUSH: takes priority over pushes and the pop.
  - At the edge: FIFO emptied, output stage forced idle (REG_WR_SEL=4'hF, PC_REG_EN=0).
  - Handshakes completing in the FLUSH cycle are discarded.
  - A write already presented on the outputs during the FLUSH cycle still completes at that edge; only later writes are suppressed.
- No X propagation: DEST/DATA are sampled only on a completed handshake.

Test Plan:
- Single ALU push, ALU_DEST=3, ALU_DATA=32'hDEADBEEF at E0 -> REG_WR_SEL=3, REG_INPUT_BUS=32'hDEADBEEF for exactly the cycle after E1, then 4'hF; PENDING[3] high from after E0 to after E2.
- Simultaneous LD(dest 5, 32'h1111) and ALU(dest 5, 32'h2222), count=0 -> two consecutive writes to r5, 32'h1111 then 32'h2222; FIFO_COUNT peaks at 2.
- Fill with DEPTH=4, both sources valid every cycle -> LD_READY/ALU_READY drop as specified; at count=3 only the load is accepted; results retire in acceptance order with no loss or duplication.
- PC write, ALU_DEST=15, ALU_DATA=32'h00000100 -> PC_REG_EN=1 and PC_IN_BUS=32'h100 for one cycle; REG_WR_SEL stays 4'hF throughout; PENDING[15] set then cleared.
- FLUSH with 3 entries queued and one on the outputs -> the presented write completes, the queued three never appear, FIFO_COUNT=0, PENDING=0 after the edge.
- ACLR asserted between clock edges with 2 entries queued -> outputs go to reset values immediately; after release, no stale writes appear.
